// File: rtl/pixel_rx_pkg.sv
// Shared definitions for the pixel readout receiver.
//   PIX_W / WORD_W / PIX_PER_WORD : pixel, bus word and pixels-per-word sizes
//   word_entry_t                  : one buffered bus word with its frame tags
//   ser_state_t                   : serializer FSM states
//   byte_sel()                    : extract pixel n (0 = bits [7:0]) from a word
package pixel_rx_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sof;
        logic              eof;
    } word_entry_t;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    function automatic logic [PIX_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
        logic [PIX_W-1:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// Synchronous word FIFO for tagged pixel words.
//   clk, reset (sync, active-low)
//   push, push_data : write request and entry
//   pop, pop_data   : read request and head entry (valid when !empty)
//   full, empty     : occupancy status
//   drop            : push refused because the FIFO was full and not popping
// A pop in the same cycle as a push on a full FIFO frees the slot first,
// so that push is accepted.
module pixel_word_fifo
    import pixel_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  word_entry_t push_data,
    input  logic        pop,
    output word_entry_t pop_data,
    output logic        full,
    output logic        empty,
    output logic        drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    word_entry_t  mem_r [DEPTH];
    logic         do_pop_s;
    logic         do_push_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign drop      = push && !do_push_s;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_readout_rx.sv
// Pixel readout receiver: captures 32-bit words from the shared pixel bus
// during read phases, tags frame start/end, buffers them and serializes
// them as a byte stream with valid/ready handshake.
//   clk, reset (sync, active-low)
//   read, data_in             : readout strobe and bus word (pixel0 in [7:0])
//   pix_data/valid/ready      : output byte stream
//   pix_sof, pix_eof          : first / last byte of a frame
//   frame_done                : one-cycle pulse after the eof byte transfers
//   overflow, frame_err       : sticky error flags
module pixel_readout_rx
    import pixel_rx_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] data_in,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eof,
    output logic        frame_done,
    output logic        overflow,
    output logic        frame_err
);

    localparam logic [7:0] WPF_C = 8'(WORDS_PER_FRAME);

    // Capture side
    logic        armed_r;
    logic [7:0]  cnt_r;
    logic        stage_valid_r;
    word_entry_t stage_r;
    logic        overflow_r;
    logic        frame_err_r;
    logic        sample_s;
    logic        load_s;
    logic        long_s;
    logic        push_s;
    logic        short_s;
    word_entry_t push_entry_s;

    // FIFO interface
    word_entry_t fifo_data_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        fifo_drop_s;
    logic        pop_s;

    // Serializer side
    ser_state_t  state_r;
    word_entry_t word_r;
    logic [1:0]  idx_r;
    logic [7:0]  pix_data_r;
    logic        pix_valid_r;
    logic        pix_sof_r;
    logic        pix_eof_r;
    logic        frame_done_r;
    logic        xfer_s;
    logic        last_s;

    // armed_r only rises after read has been seen low, so a read phase that
    // was already in progress at reset release is ignored entirely.
    assign sample_s = read && armed_r;
    assign load_s   = sample_s && (cnt_r < WPF_C);
    assign long_s   = sample_s && (cnt_r >= WPF_C);
    assign push_s   = stage_valid_r && (sample_s || !read);
    assign short_s  = push_s && !read && !stage_r.eof;

    // Word leaving staging: read falling marks it as the last of its frame.
    always_comb begin
        push_entry_s = stage_r;
        if (!read) begin
            push_entry_s.eof = 1'b1;
        end else begin
            push_entry_s.eof = stage_r.eof;
        end
    end

    // Capture, word counting, staging and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_r       <= 1'b0;
            cnt_r         <= 8'd0;
            stage_valid_r <= 1'b0;
            stage_r       <= '0;
            overflow_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            armed_r <= armed_r | ~read;
            if (!read) begin
                cnt_r <= 8'd0;
            end else if (sample_s && (cnt_r != 8'hFF)) begin
                cnt_r <= cnt_r + 8'd1;
            end
            stage_valid_r <= load_s;
            if (load_s) begin
                stage_r.data <= data_in;
                stage_r.sof  <= (cnt_r == 8'd0);
                stage_r.eof  <= ((cnt_r + 8'd1) == WPF_C);
            end
            overflow_r  <= overflow_r | fifo_drop_s;
            frame_err_r <= frame_err_r | long_s | short_s;
        end
    end

    pixel_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .drop      (fifo_drop_s)
    );

    assign xfer_s = pix_valid_r && pix_ready;
    assign last_s = xfer_s && (idx_r == 2'd3);
    // Pop when idle, or right as the last byte leaves so there is no bubble.
    assign pop_s  = !fifo_empty_s && ((state_r == SER_IDLE) || last_s);

    // Serializer FSM with registered byte outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= SER_IDLE;
            word_r       <= '0;
            idx_r        <= 2'd0;
            pix_data_r   <= 8'h00;
            pix_valid_r  <= 1'b0;
            pix_sof_r    <= 1'b0;
            pix_eof_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= xfer_s && pix_eof_r;
            if (pop_s) begin
                state_r     <= SER_SHIFT;
                word_r      <= fifo_data_s;
                idx_r       <= 2'd0;
                pix_data_r  <= byte_sel(fifo_data_s.data, 2'd0);
                pix_valid_r <= 1'b1;
                pix_sof_r   <= fifo_data_s.sof;
                pix_eof_r   <= 1'b0;
            end else if (last_s) begin
                state_r     <= SER_IDLE;
                idx_r       <= 2'd0;
                pix_valid_r <= 1'b0;
                pix_sof_r   <= 1'b0;
                pix_eof_r   <= 1'b0;
            end else if (xfer_s) begin
                idx_r      <= idx_r + 2'd1;
                pix_data_r <= byte_sel(word_r.data, idx_r + 2'd1);
                pix_sof_r  <= 1'b0;
                pix_eof_r  <= word_r.eof && (idx_r == 2'd2);
            end
        end
    end

    assign pix_data   = pix_data_r;
    assign pix_valid  = pix_valid_r;
    assign pix_sof    = pix_sof_r;
    assign pix_eof    = pix_eof_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_pixel_readout_rx.sv
// Self-checking bench for pixel_readout_rx (WORDS_PER_FRAME=3, FIFO_DEPTH=4).
// Expected byte streams are built per read phase from the frame rules and
// compared against a monitor of accepted bytes.
module tb_pixel_readout_rx;

    localparam int WPF   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_eof;
    logic        frame_done;
    logic        overflow;
    logic        frame_err;

    pixel_readout_rx #(
        .WORDS_PER_FRAME (WPF),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .data_in    (data_in),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eof    (pix_eof),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // {sof, eof, byte}
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    bit         exp_err = 1'b0;
    int         ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
    int         cyc = 0;
    int         first_cyc = 0;
    int         lat_cyc = 0;
    bit         lat_arm = 1'b0;

    // monitor state
    bit         prev_stall = 1'b0;
    bit         prev_eofx = 1'b0;
    bit         prev_mid = 1'b0;
    logic [10:0] prev_out = '0;
    int         pos = 0;
    bit         xfer;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b0;
                1:       pix_ready = 1'b1;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            prev_eofx  = 1'b0;
            prev_mid   = 1'b0;
            pos        = 0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(prev_eofx));
            if (prev_stall)
                check("stall_hold", 32'({pix_valid, pix_sof, pix_eof, pix_data}), 32'(prev_out));
            if (prev_mid && pix_ready)
                check("no_bubble", 32'(pix_valid), 32'd1);
            if (lat_arm && pix_valid) begin
                lat_cyc = cyc;
                lat_arm = 1'b0;
            end
            xfer = pix_valid && pix_ready;
            if (xfer) got_q.push_back({pix_sof, pix_eof, pix_data});
            prev_stall = pix_valid && !pix_ready;
            prev_out   = {pix_valid, pix_sof, pix_eof, pix_data};
            prev_eofx  = xfer && pix_eof;
            prev_mid   = xfer && (pos != 3);
            if (xfer) pos = (pos + 1) % 4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [31:0] w, input bit sof, input bit eof);
        for (int b = 0; b < 4; b++)
            exp_q.push_back({(b == 0) && sof, (b == 3) && eof, w[8*b +: 8]});
    endtask

    // One read phase of len words; only the first `keep` framed words are expected out.
    task automatic send_frame(input int len, input int keep);
        int n;
        logic [31:0] w;
        n = (len < WPF) ? len : WPF;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            data_in = w;
            read = 1'b1;
            if (i < n && i < keep) add_word(w, i == 0, i == n - 1);
            tick();
            if (i == 0) first_cyc = cyc;
        end
        read = 1'b0;
        data_in = $urandom;
        if (len != WPF) exp_err = 1'b1;
    endtask

    task automatic drain_compare(input string tag);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 400) begin
            tick();
            t++;
        end
        repeat (10) tick();
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        ready_mode = 1;
        read = 1'b1;
        data_in = 32'hDEADBEEF;
        repeat (3) tick();
        check("reset_ctrl", 32'({pix_valid, pix_sof, pix_eof, frame_done, overflow, frame_err}), 32'd0);
        check("reset_data", 32'(pix_data), 32'h00);

        // read already high at release: that phase must be ignored
        reset = 1'b1;
        repeat (4) tick();
        read = 1'b0;
        tick();
        drain_compare("orphan");
        check("orphan_err", 32'(frame_err), 32'd0);

        // normal frame with latency bound
        lat_arm = 1'b1;
        send_frame(WPF, WPF);
        tick();
        drain_compare("normal");
        check("latency_min", 32'((lat_cyc - first_cyc) >= 2), 32'd1);
        check("normal_err", 32'(frame_err), 32'd0);

        // random frames: short, exact, long, random backpressure
        for (int f = 0; f < 16; f++) begin
            ready_mode = $urandom_range(1, 2);
            if (f == 7) send_frame(260, WPF);
            else        send_frame($urandom_range(1, 5), WPF);
            tick();
            drain_compare($sformatf("rnd%0d", f));
            check("rnd_err", 32'(frame_err), 32'(exp_err));
            check("rnd_ovf", 32'(overflow), 32'd0);
        end

        // back-to-back frames with one idle cycle between
        ready_mode = 1;
        send_frame(WPF, WPF);
        tick();
        send_frame(WPF, WPF);
        tick();
        drain_compare("b2b");

        // overflow: stalled output, 1 word in serializer + DEPTH in FIFO survive
        ready_mode = 0;
        tick();
        send_frame(WPF, WPF);
        tick();
        send_frame(WPF, 1 + DEPTH - WPF);
        repeat (10) tick();
        check("ovf_flag", 32'(overflow), 32'd1);
        ready_mode = 1;
        drain_compare("ovf");
        check("ovf_err", 32'(frame_err), 32'(exp_err));

        // reset mid-serialization, after byte 1 of the first word
        send_frame(WPF, WPF);
        begin
            int t;
            t = 0;
            while (got_q.size() < 2 && t < 100) begin
                tick();
                t++;
            end
            check("mid_wait", 32'(got_q.size() >= 2), 32'd1);
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_flags", 32'({pix_sof, pix_eof, frame_done, overflow, frame_err}), 32'd0);
        check("rst_data", 32'(pix_data), 32'h00);
        got_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        repeat (20) tick();
        check("rst_quiet", 32'(got_q.size()), 32'd0);

        // capture works again after reset
        send_frame(WPF, WPF);
        tick();
        drain_compare("post_rst");
        check("post_rst_err", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
